// File: rtl/counter_sweep_ctrl_if.sv
// Host/counter-side signal bundle for counter_sweep_ctrl; the abort wire exists only under SWEEP_CTRL_ABORT_EN.
// slave = the sequencer itself, master = whoever drives start/bounds/count and observes the controls.
interface counter_sweep_ctrl_if #(
    parameter int WIDTH  = 5,
    parameter int PASS_W = 4
);
    logic              start;
    logic [WIDTH-1:0]  lo;
    logic [WIDTH-1:0]  hi;
    logic [PASS_W-1:0] passes;
    logic [WIDTH-1:0]  count;
    logic              enable;
    logic              updown;
    logic              busy;
    logic              done;
    logic              err;
    logic [PASS_W-1:0] pass_cnt;
`ifdef SWEEP_CTRL_ABORT_EN
    logic              abort;

    modport slave (
        input  start, lo, hi, passes, count, abort,
        output enable, updown, busy, done, err, pass_cnt
    );
    modport master (
        output start, lo, hi, passes, count, abort,
        input  enable, updown, busy, done, err, pass_cnt
    );
`else
    modport slave (
        input  start, lo, hi, passes, count,
        output enable, updown, busy, done, err, pass_cnt
    );
    modport master (
        output start, lo, hi, passes, count,
        input  enable, updown, busy, done, err, pass_cnt
    );
`endif
endinterface

// File: rtl/counter_sweep_ctrl.sv
// Triangle-sweep sequencer for an up/down counter (seek lo, up to hi, dwell, down to lo, dwell, x passes); SWEEP_CTRL_ABORT_EN adds abort.
// Latency: one counter step per enabled cycle, enable/updown are combinational; no backpressure, start is only taken in IDLE.
module counter_sweep_ctrl #(
    parameter int WIDTH        = 5,
    parameter int PASS_W       = 4,
    parameter int DWELL_CYCLES = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    counter_sweep_ctrl_if.slave io_sweep
);
    localparam int DW = $clog2(DWELL_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEEK,
        S_UP,
        S_DWELL_HI,
        S_DOWN,
        S_DWELL_LO,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [WIDTH-1:0]  r_lo;
    logic [WIDTH-1:0]  r_hi;
    logic [PASS_W-1:0] r_passes;
    logic [PASS_W-1:0] r_pass_cnt;
    logic [DW-1:0]     r_dwell;
    logic              r_err;

    logic              w_start_ok;
    logic              w_accept;
    logic              w_at_lo;
    logic              w_at_hi;
    logic              w_in_dwell;
    logic              w_dwell_end;
    logic [PASS_W-1:0] w_pass_inc;
    logic              w_last_pass;
    logic              w_abort;
    logic              w_enable;
    logic              w_updown;

`ifdef SWEEP_CTRL_ABORT_EN
    assign w_abort = io_sweep.abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_start_ok  = (io_sweep.lo <= io_sweep.hi) && (io_sweep.passes != '0);
    assign w_accept    = (r_state == S_IDLE) && io_sweep.start && w_start_ok;
    assign w_at_lo     = (io_sweep.count == r_lo);
    assign w_at_hi     = (io_sweep.count == r_hi);
    assign w_in_dwell  = (r_state == S_DWELL_HI) || (r_state == S_DWELL_LO);
    assign w_dwell_end = (r_dwell == DW'(DWELL_CYCLES - 1));
    assign w_pass_inc  = r_pass_cnt + 1'b1;
    assign w_last_pass = (w_pass_inc == r_passes);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:     if (w_accept)    w_next_state = S_SEEK;
            S_SEEK:     if (w_at_lo)     w_next_state = S_UP;
            S_UP:       if (w_at_hi)     w_next_state = S_DWELL_HI;
            S_DWELL_HI: if (w_dwell_end) w_next_state = S_DOWN;
            S_DOWN:     if (w_at_lo)     w_next_state = w_last_pass ? S_DONE : S_DWELL_LO;
            S_DWELL_LO: if (w_dwell_end) w_next_state = S_UP;
            S_DONE:                      w_next_state = S_IDLE;
            default:                     w_next_state = S_IDLE;
        endcase
        if (w_abort && (r_state != S_IDLE)) begin
            w_next_state = S_IDLE;
        end
    end

    // Bounds are checked before enabling, so the counter stops on lo/hi and can never wrap.
    always_comb begin
        w_enable = 1'b0;
        w_updown = 1'b1;
        case (r_state)
            S_SEEK: begin
                w_updown = (io_sweep.count < r_lo);
                w_enable = !w_at_lo;
            end
            S_UP: begin
                w_enable = !w_at_hi;
            end
            S_DOWN: begin
                w_updown = 1'b0;
                w_enable = !w_at_lo;
            end
            default: begin
                w_enable = 1'b0;
            end
        endcase
        if (w_abort) begin
            w_enable = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_lo       <= '0;
            r_hi       <= '0;
            r_passes   <= '0;
            r_pass_cnt <= '0;
            r_dwell    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= (r_state == S_IDLE) && io_sweep.start && !w_start_ok;
            if (w_accept) begin
                r_lo       <= io_sweep.lo;
                r_hi       <= io_sweep.hi;
                r_passes   <= io_sweep.passes;
                r_pass_cnt <= '0;
            end else if ((r_state == S_DOWN) && w_at_lo && !w_abort) begin
                r_pass_cnt <= w_pass_inc;
            end
            // Restarts from zero on every dwell entry because any other state clears it.
            if (w_in_dwell && (w_next_state == r_state)) begin
                r_dwell <= r_dwell + 1'b1;
            end else begin
                r_dwell <= '0;
            end
        end
    end

    assign io_sweep.enable   = w_enable;
    assign io_sweep.updown   = w_updown;
    assign io_sweep.busy     = (r_state != S_IDLE);
    assign io_sweep.done     = (r_state == S_DONE);
    assign io_sweep.err      = r_err;
    assign io_sweep.pass_cnt = r_pass_cnt;
endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl: vector table, random sweeps against a trace model, reset/abort corner sequences.
module tb_counter_sweep_ctrl;
    localparam int WIDTH  = 5;
    localparam int PASS_W = 4;
    localparam int DWELL  = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    counter_sweep_ctrl_if #(.WIDTH(WIDTH), .PASS_W(PASS_W)) sif ();

    counter_sweep_ctrl #(
        .WIDTH(WIDTH),
        .PASS_W(PASS_W),
        .DWELL_CYCLES(DWELL)
    ) dut (
        .i_clk(clk),
        .i_reset(rst_n),
        .io_sweep(sif.slave)
    );

    // The controlled up/down counter, with a load port so the bench can place count anywhere.
    logic [WIDTH-1:0] cnt;
    logic             ld;
    logic [WIDTH-1:0] ld_val;
    always @(posedge clk) begin
        if (ld) cnt <= ld_val;
        else if (sif.enable) cnt <= sif.updown ? cnt + 1'b1 : cnt - 1'b1;
    end
    assign sif.count = cnt;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    typedef struct {
        int cnt;
        int en;
        int ud_chk;
        int ud;
        int dn;
        int pc;
    } step_t;

    step_t tr[$];

    function automatic step_t mk(int c, int en, int uc, int ud, int dn, int pc);
        step_t s;
        s.cnt = c; s.en = en; s.ud_chk = uc; s.ud = ud; s.dn = dn; s.pc = pc;
        return s;
    endfunction

    // Expected per-cycle trajectory of a whole sweep, derived directly from the sweep rules.
    task automatic build_trace(input int c0, input int lo, input int hi, input int p);
        int c;
        c = c0;
        tr.delete();
        while (c != lo) begin
            tr.push_back(mk(c, 1, 1, (c < lo) ? 1 : 0, 0, 0));
            c += (c < lo) ? 1 : -1;
        end
        tr.push_back(mk(lo, 0, 1, 0, 0, 0));
        for (int k = 0; k < p; k++) begin
            for (int v = lo; v < hi; v++) tr.push_back(mk(v, 1, 1, 1, 0, k));
            tr.push_back(mk(hi, 0, 1, 1, 0, k));
            repeat (DWELL) tr.push_back(mk(hi, 0, 0, 0, 0, k));
            for (int v = hi; v > lo; v--) tr.push_back(mk(v, 1, 1, 0, 0, k));
            tr.push_back(mk(lo, 0, 1, 0, 0, k));
            if (k == p - 1) tr.push_back(mk(lo, 0, 0, 0, 1, k + 1));
            else repeat (DWELL) tr.push_back(mk(lo, 0, 0, 0, 0, k + 1));
        end
    endtask

    task automatic set_count(input int v);
        ld = 1'b1;
        ld_val = WIDTH'(v);
        @(negedge clk);
        ld = 1'b0;
    endtask

    // Entered and left at a falling edge with the sequencer idle.
    task automatic run_sweep(input int lo, input int hi, input int p, input int exp_err, input int noise);
        int c0;
        c0 = int'(cnt);
        sif.start  = 1'b1;
        sif.lo     = WIDTH'(lo);
        sif.hi     = WIDTH'(hi);
        sif.passes = PASS_W'(p);
        @(negedge clk);
        sif.start = 1'b0;
        if (exp_err != 0) begin
            chk("reject_err", 32'(sif.err), 1);
            chk("reject_busy", 32'(sif.busy), 0);
            chk("reject_enable", 32'(sif.enable), 0);
            @(negedge clk);
            chk("reject_err_clear", 32'(sif.err), 0);
            chk("reject_still_idle", 32'(sif.busy), 0);
            return;
        end
        build_trace(c0, lo, hi, p);
        foreach (tr[i]) begin
            chk("trace_count", 32'(cnt), tr[i].cnt);
            chk("trace_enable", 32'(sif.enable), tr[i].en);
            chk("trace_busy", 32'(sif.busy), 1);
            chk("trace_done", 32'(sif.done), tr[i].dn);
            chk("trace_err", 32'(sif.err), 0);
            chk("trace_pass_cnt", 32'(sif.pass_cnt), tr[i].pc);
            if (tr[i].ud_chk != 0) chk("trace_updown", 32'(sif.updown), tr[i].ud);
            if (noise != 0) begin
                sif.start  = 1'($urandom);
                sif.lo     = WIDTH'($urandom);
                sif.hi     = WIDTH'($urandom);
                sif.passes = PASS_W'($urandom);
            end
            @(negedge clk);
        end
        sif.start = 1'b0;
        chk("end_busy", 32'(sif.busy), 0);
        chk("end_done", 32'(sif.done), 0);
        chk("end_pass_cnt", 32'(sif.pass_cnt), p);
        chk("end_count", 32'(cnt), lo);
        chk("end_enable", 32'(sif.enable), 0);
        chk("end_updown", 32'(sif.updown), 1);
    endtask

    typedef struct {
        int c0;
        int lo;
        int hi;
        int p;
        int exp_err;
        int noise;
    } vec_t;

    vec_t vt[8];

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, busy=%0d", sif.busy);
        $fatal(1, "watchdog");
    end

    initial begin
        int lo, hi, p, found, held;
        vt[0] = '{0, 3, 7, 1, 0, 0};
        vt[1] = '{7, 0, 31, 2, 0, 0};
        vt[2] = '{5, 9, 4, 1, 1, 0};
        vt[3] = '{5, 4, 4, 0, 1, 0};
        vt[4] = '{5, 4, 4, 2, 0, 1};
        vt[5] = '{31, 31, 31, 1, 0, 0};
        vt[6] = '{20, 10, 12, 15, 0, 1};
        vt[7] = '{0, 0, 0, 1, 0, 1};

        sif.start  = 1'b0;
        sif.lo     = '0;
        sif.hi     = '0;
        sif.passes = '0;
`ifdef SWEEP_CTRL_ABORT_EN
        sif.abort  = 1'b0;
`endif
        ld     = 1'b1;
        ld_val = '0;
        rst_n  = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("reset_enable", 32'(sif.enable), 0);
            chk("reset_busy", 32'(sif.busy), 0);
            chk("reset_pass_cnt", 32'(sif.pass_cnt), 0);
            chk("reset_done", 32'(sif.done), 0);
            chk("reset_err", 32'(sif.err), 0);
            chk("reset_updown", 32'(sif.updown), 1);
        end
        rst_n = 1'b1;
        ld    = 1'b0;
        @(negedge clk);
        chk("post_reset_busy", 32'(sif.busy), 0);

        foreach (vt[i]) begin
            set_count(vt[i].c0);
            run_sweep(vt[i].lo, vt[i].hi, vt[i].p, vt[i].exp_err, vt[i].noise);
        end

        for (int n = 0; n < 30; n++) begin
            lo = $urandom_range(0, 31);
            hi = $urandom_range(0, 31);
            p  = $urandom_range(0, 3);
            set_count($urandom_range(0, 31));
            run_sweep(lo, hi, p, ((lo > hi) || (p == 0)) ? 1 : 0, 1);
        end

        // Reset asserted mid-DOWN must drop enable without waiting for an edge.
        set_count(1);
        sif.start  = 1'b1;
        sif.lo     = WIDTH'(1);
        sif.hi     = WIDTH'(6);
        sif.passes = PASS_W'(1);
        @(negedge clk);
        sif.start = 1'b0;
        found = 0;
        for (int k = 0; k < 100 && found == 0; k++) begin
            if (sif.busy && sif.enable && !sif.updown) found = 1;
            else @(negedge clk);
        end
        chk("wait_down", 32'(found), 1);
        chk("down_first_count", 32'(cnt), 6);
        held = int'(cnt);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_enable", 32'(sif.enable), 0);
        chk("async_reset_busy", 32'(sif.busy), 0);
        @(negedge clk);
        chk("reset_count_hold", 32'(cnt), held);
        chk("reset_pass_cnt_clear", 32'(sif.pass_cnt), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_reset_idle", 32'(sif.busy), 0);

`ifdef SWEEP_CTRL_ABORT_EN
        set_count(2);
        sif.start  = 1'b1;
        sif.lo     = WIDTH'(2);
        sif.hi     = WIDTH'(9);
        sif.passes = PASS_W'(1);
        @(negedge clk);
        sif.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_pre_count", 32'(cnt), 5);
        chk("abort_pre_enable", 32'(sif.enable), 1);
        sif.abort = 1'b1;
        #1;
        chk("abort_enable_comb", 32'(sif.enable), 0);
        chk("abort_busy_same_cycle", 32'(sif.busy), 1);
        @(negedge clk);
        sif.abort = 1'b0;
        chk("abort_idle", 32'(sif.busy), 0);
        chk("abort_no_done", 32'(sif.done), 0);
        chk("abort_count", 32'(cnt), 5);
        chk("abort_pass_cnt", 32'(sif.pass_cnt), 0);
        @(negedge clk);
        chk("abort_count_hold", 32'(cnt), 5);
        chk("abort_done_quiet", 32'(sif.done), 0);
        sif.abort = 1'b1;
        @(negedge clk);
        sif.abort = 1'b0;
        chk("idle_abort_busy", 32'(sif.busy), 0);
        chk("idle_abort_err", 32'(sif.err), 0);
        chk("idle_abort_updown", 32'(sif.updown), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/counter_sweep_ctrl.md
Name: counter_sweep_ctrl

Overview:
- Sequencer that drives the enable/updown controls of the team's up/down counter (WIDTH-bit count, clk/reset/enable/updown ports).
- On a start command it performs a programmed triangle sweep: seek to lo, count up to hi, dwell, count down to lo, dwell, repeated a programmed number of passes.
- Sits between a test/host controller and a counter instance, and closes the loop on the counter's count output.

Parameters:
- WIDTH, 5, counter and bound width.
- PASS_W, 4, width of pass-count fields.
- DWELL_CYCLES, 4, idle cycles (enable=0) at each turnaround; must be at least 1.

Ports:
- clk  input  1  rising-edge clock shared with the counter.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- lo  input  WIDTH  lower sweep bound; captured on an accepted start.
- hi  input  WIDTH  upper sweep bound; captured on an accepted start.
- passes  input  PASS_W  number of up+down passes; captured on an accepted start.
- count  input  WIDTH  current value from the counter's count output.
- enable  output  1  to counter enable; combinational from state, count and latched bounds.
- updown  output  1  to counter updown; 1 = up, 0 = down.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a sweep completes.
- err  output  1  one-cycle pulse when a start is rejected.
- pass_cnt  output  PASS_W  completed passes in the current or last sweep.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, enable=0, updown=1, busy=0, done=0, err=0, pass_cnt=0, latched bounds=0. enable goes low immediately on reset assertion, without waiting for a clock edge.
- States: IDLE, SEEK, UP, DWELL_HI, DOWN, DWELL_LO, DONE.
- IDLE: enable=0, updown=1.
  - start with lo<=hi and passes!=0: latch lo/hi/passes, clear pass_cnt, go to SEEK.
  - start otherwise: err pulses next cycle, stay in IDLE.
- SEEK:
  - updown = (count<lo).
  - enable = (count!=lo).
  - When count==lo, go to UP.
- UP:
  - updown=1, enable = (count!=hi).
  - When count==hi, go to DWELL_HI. The counter therefore stops exactly at hi, with no overshoot.
- DWELL_HI: enable=0 for DWELL_CYCLES cycles, then go to DOWN.
- DOWN:
  - updown=0, enable = (count!=lo).
  - When count==lo, increment pass_cnt.
  - If the incremented pass_cnt equals passes, go to DONE; otherwise go to DWELL_LO.
- DWELL_LO: enable=0 for DWELL_CYCLES cycles, then go to UP.
- DONE: enable=0, done=1 for exactly one cycle, then go to IDLE. pass_cnt holds its value until the next accepted start.
- Latency: exactly one counter step per cycle while enable=1. Cycles in UP = hi-lo+1 (the final cycle has enable=0). DOWN is the same.
- Boundary conditions:
  - lo==hi: UP and DOWN each last one cycle with enable=0; only the dwells consume time.
  - lo=0 and hi=2^WIDTH-1 are legal; the counter never wraps because bounds are compared before enabling.
  - start while busy is ignored (no err).
  - Changes to lo/hi/passes inputs during a sweep have no effect.
  - If count changes externally (e.g. the counter is reset), the FSM follows count via comparisons. SEEK/UP/DOWN still converge because they are direction-correct.
- Dwell counter width is clog2(DWELL_CYCLES+1); it resets to 0 on each dwell entry.

Optional Feature:
- Macro: SWEEP_CTRL_ABORT_EN.
- Defined: adds input abort (1 bit). abort=1 in any busy state forces enable=0 combinationally and moves to IDLE on the next edge. done is not pulsed and pass_cnt holds. abort in IDLE has no effect.
- Undefined: the abort port does not exist, and a sweep can only end via DONE or reset.

Test Plan:
- Reset with reset=0 for 2 cycles, then release -> enable=0, busy=0, pass_cnt=0 throughout reset.
- count=0, start with lo=3, hi=7, passes=1, DWELL_CYCLES=4 -> 3 enabled up steps in SEEK, 4 up steps to 7, 4 dwell cycles, 4 down steps to 3, done pulse, pass_cnt=1, count ends at 3.
- lo=0, hi=31, passes=2 -> count reaches 31 twice with no wrap to 0, done after second return to 0, pass_cnt=2.
- start with lo=9, hi=4 (and separately passes=0) -> err one-cycle pulse, busy stays 0, enable stays 0.
- Second start pulse mid-sweep with different bounds -> ignored; the sweep completes on the original bounds.
- With SWEEP_CTRL_ABORT_EN defined: abort during UP at count=5 -> enable=0 in the same cycle, IDLE next cycle, no done, count holds at 5. Also assert reset mid-DOWN -> enable drops asynchronously.
